uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver for the serial link; it is the receive-side counterpart of the transmit path and its baud timing. It turns the asynchronous `rx` line into bytes, 8N1 by default. The bit timing is derived internally from `clk`. Each byte is presented with a one-cycle `valid` strobe. Framing errors, and optionally parity errors, are flagged to the consuming logic (flash command parser, loopback).

## Interface
- `BandRate`, 115200: line baud rate.
- `InclkFreq`, 50_000_000: `clk` frequency in Hz.
- `ClkPerBit`, derived, `InclkFreq / BandRate` (integer divide): clocks per bit, 434 by default. Must be at least 8. Elaboration error otherwise.
- `HalfBit`, derived, `ClkPerBit / 2`: clocks from start edge to mid-start-bit.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `rx`, in, 1: serial line, idle high, asynchronous to `clk`.
- `data`, out, 8: last received byte. Reset value 0. Updated only together with `valid`.
- `valid`, out, 1: one-cycle pulse when a byte with a good stop bit is received. Reset value 0.
- `frame_err`, out, 1: one-cycle pulse when the stop bit samples low. Reset value 0.
- `busy`, out, 1: high whenever the state is not IDLE. Reset value 0.

## Operation
- `rx` passes through a 2-flop synchronizer, reset to 1, to give `rx_s`. A third flop, `rx_d`, forms a falling-edge detect: `rx_d==1 && rx_s==0`.
- Bit counter `cnt` is 16 bits wide and counts 0..ClkPerBit-1. Bit index `idx` is 3 bits wide. The shift register is 8 bits, LSB first: on each sample it shifts right and inserts `rx_s` at bit 7.
- States and transitions:
  - IDLE: on a falling edge, go to START with cnt=0. A line held low (break) never retriggers, because an edge is required.
  - START: when cnt==HalfBit-1, check `rx_s`. If it is 0, go to DATA with cnt=0 and idx=0. If it is 1, treat it as a glitch and go to IDLE with no flags.
  - DATA: when cnt==ClkPerBit-1, sample the bit and set cnt=0. After idx==7 is sampled, go to PARITY if enabled, otherwise to STOP. Otherwise increment idx.
  - PARITY (macro only): when cnt==ClkPerBit-1, compare `rx_s` with the even parity of the shift register, then go to STOP.
  - STOP: when cnt==ClkPerBit-1, sample and go to IDLE.
    - If the sample is 1: load `data` from the shift register and pulse `valid`.
    - If the sample is 0: pulse `frame_err`, leave `data` unchanged, no `valid`.
- `valid` and `frame_err` are mutually exclusive.
- Reset mid-frame: everything returns to reset values at once. The partial byte is discarded and no flags are raised.
- There is no back-pressure. The consumer must take `data` before the next `valid`, one frame time later.

## Timing
- Sample points are mid-bit. Data bit k is sampled HalfBit + (k+1)*ClkPerBit clocks after the edge detect. The stop bit is sampled HalfBit + 9*ClkPerBit clocks after the edge detect, or 10*ClkPerBit with parity.
- `valid`/`frame_err` are registered and go high on the clock after the stop sample, for exactly 1 cycle.
- Latency from `rx` falling to the edge-detect cycle is 3 clocks (synchronizer plus edge flop).
- The earliest next start edge is accepted in the cycle after returning to IDLE. This tolerates a stop bit down to about half a bit long.
- `busy` rises on the cycle after the edge detect. It falls on the same edge that raises `valid`/`frame_err`.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: even parity bit after bit 7, which adds the PARITY state. Adds output `parity_err` (1 bit, reset 0). `parity_err` pulses in the same cycle as `valid` or `frame_err` when the parity check failed. `data` is still loaded if the stop bit is good.
  - Undefined: 8N1 only. There is no PARITY state and no `parity_err` port.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - default `BandRate`/`InclkFreq` constants;
  - a `clk_per_bit(freq, baud)` function.
- The transmitter uses the same package.
- Sub-module `uart_sync`: 2-flop synchronizer plus falling-edge detect. Outputs are `rx_s` and `fall`; reset value is line high.

## Test plan
Simulation parameters: InclkFreq=16, BandRate=1, giving ClkPerBit=16 and HalfBit=8.
- Send 0xA5 8N1 at the nominal rate. `valid` pulses once 1 cycle after the stop sample, `data`=0xA5, `frame_err`=0, `busy` low afterwards.
- Send 0x00 then 0xFF back to back, with a 1-bit stop and no idle gap. Two `valid` pulses occur, with `data` 0x00 then 0xFF.
- Send a 5-clock low glitch on idle `rx`. The FSM returns to IDLE at the mid-start check with no `valid` and no `frame_err`.
- Send 0x3C with the stop bit driven low, then hold `rx` low for 40 clocks. There is one `frame_err` pulse, `data` keeps its previous value, and there is no retrigger while low.
- Assert `rst_n` low during data bit 4 of a frame, then release it and send 0x5A. Outputs read 0 during reset, no flag comes from the aborted frame, and the next frame gives `data`=0x5A.
- With `UART_RX_PARITY_EN`:
  - send 0x07 with parity bit 0 (wrong): `valid` and `parity_err` pulse in the same cycle;
  - send 0x07 with parity bit 1: `parity_err` stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default line settings, bit timing.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int unsigned BandRateDef  = 115200;
  localparam int unsigned InclkFreqDef = 50_000_000;

  function automatic int unsigned clk_per_bit(
    input int unsigned freq,
    input int unsigned baud
  );
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a falling-edge detect flop.
module uart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      dly_q  <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign rx_s = sync_q;
  assign fall = dly_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1; define UART_RX_PARITY_EN for 8E1 with a parity_err pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BandRate  = BandRateDef,
  parameter int unsigned InclkFreq = InclkFreqDef
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int unsigned ClkPerBit = clk_per_bit(InclkFreq, BandRate);
  localparam int unsigned HalfBit   = ClkPerBit / 2;
  localparam logic [15:0] BitLast   = 16'(ClkPerBit - 1);
  localparam logic [15:0] HalfLast  = 16'(HalfBit - 1);

  if (ClkPerBit < 8) begin : g_bad_rate
    $error("uart_rx: ClkPerBit must be at least 8");
  end

  logic rx_s;
  logic fall;

  uart_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (fall)
  );

  uart_state_e state_q;
  logic [15:0] cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        ferr_q;
`ifdef UART_RX_PARITY_EN
  logic        par_bad_q;
  logic        perr_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (fall) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == HalfLast) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            // A line back high at mid-start was only a glitch
            state_q <= rx_s ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DATA: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == BitLast) begin
            cnt_q     <= '0;
            par_bad_q <= rx_s ^ (^shift_q);
            state_q   <= STOP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
`endif
        STOP: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (rx_s) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            perr_q <= par_bad_q;
`endif
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx against a frame-level line model (ClkPerBit=16).
module tb_uart_rx;

  localparam int C = 16;
  localparam int H = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`else
  logic       parity_err = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic       line[$];
  logic       ev_v[];
  logic       ev_f[];
  logic       ev_p[];
  logic       ev_b[];
  logic [7:0] ev_d[];
  int         m_first_valid;

  int         dv_t[$];
  logic [7:0] dv_d[$];
  logic       dv_p[$];
  logic [7:0] df_d[$];

  uart_rx #(
    .BandRate (1),
    .InclkFreq(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic put(input logic v, input int len);
    for (int i = 0; i < len; i++) line.push_back(v);
  endtask

  task automatic frame(input logic [7:0] b, input logic stop_v,
                       input int stop_len, input logic par_flip);
    put(1'b0, C);
    for (int k = 0; k < 8; k++) put(b[k], C);
`ifdef UART_RX_PARITY_EN
    put((^b) ^ par_flip, C);
`else
    if (par_flip) put(1'b1, 0);
`endif
    put(stop_v, stop_len);
  endtask

  function automatic logic lv(input int i);
    if (i < 0) return 1'b1;
    if (i >= line.size()) return 1'b1;
    return line[i];
  endfunction

  // Index i = value after the i-th rising edge. A line fall at position f
  // is acted on at edge f+2; bit samples sit at f+H+(k+1)*C.
  task automatic build_model();
    int n;
    int m;
    int e;
    int fin;
    logic [7:0] b;
    logic [7:0] d;
    logic [7:0] vd[];
    n = line.size();
    ev_v = new[n];
    ev_f = new[n];
    ev_p = new[n];
    ev_b = new[n];
    ev_d = new[n];
    vd   = new[n];
    for (int i = 0; i < n; i++) begin
      ev_v[i] = 0; ev_f[i] = 0; ev_p[i] = 0; ev_b[i] = 0; vd[i] = 0;
    end
    m_first_valid = -1;
    m = 0;
    while (m < n) begin
      if (lv(m - 3) && !lv(m - 2)) begin
        e = m;
        if (lv(e + H - 2)) begin
          fin = e + H;
        end else begin
          fin = e + H + NB * C;
          for (int k = 0; k < 8; k++) b[k] = lv(e + H + (k + 1) * C - 2);
          if (fin < n) begin
            if (lv(fin - 2)) begin
              ev_v[fin] = 1;
              vd[fin] = b;
              if (m_first_valid < 0) m_first_valid = fin;
            end else begin
              ev_f[fin] = 1;
            end
`ifdef UART_RX_PARITY_EN
            ev_p[fin] = lv(e + H + 9 * C - 2) != (^b);
`endif
          end
        end
        for (int i = e; i < fin && i < n; i++) ev_b[i] = 1;
        m = fin + 1;
      end else begin
        m++;
      end
    end
    d = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (ev_v[i]) d = vd[i];
      ev_d[i] = d;
    end
  endtask

  task automatic run_phase();
    build_model();
    for (int n = 0; n < line.size(); n++) begin
      rx = line[n];
      @(posedge clk);
      #1;
      chk("valid", 32'(valid), 32'(ev_v[n]));
      chk("frame_err", 32'(frame_err), 32'(ev_f[n]));
      chk("parity_err", 32'(parity_err), 32'(ev_p[n]));
      chk("busy", 32'(busy), 32'(ev_b[n]));
      chk("data", 32'(data), 32'(ev_d[n]));
      if (valid) begin
        dv_t.push_back(n);
        dv_d.push_back(data);
        dv_p.push_back(parity_err);
      end
      if (frame_err) df_d.push_back(data);
    end
  endtask

  initial begin
    logic [7:0] b;
    logic sv;
    logic pf;

    put(1'b1, 10);
    frame(8'hA5, 1'b1, C, 1'b0);
    put(1'b1, 20);
    frame(8'h00, 1'b1, C, 1'b0);
    frame(8'hFF, 1'b1, C, 1'b0);
    put(1'b1, 20);
    put(1'b0, 5);
    put(1'b1, 30);
    frame(8'h3C, 1'b0, C, 1'b0);
    put(1'b0, 40);
    put(1'b1, 30);
`ifdef UART_RX_PARITY_EN
    frame(8'h07, 1'b1, C, 1'b1);
    put(1'b1, 20);
    frame(8'h07, 1'b1, C, 1'b0);
    put(1'b1, 20);
`endif
    frame(8'hB7, 1'b1, H + 1, 1'b0);
    frame(8'h11, 1'b1, C, 1'b0);
    put(1'b1, 20);
    for (int r = 0; r < 24; r++) begin
      b  = 8'($urandom);
      sv = ($urandom_range(0, 5) != 0);
      pf = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) begin
        put(1'b0, $urandom_range(1, H - 2));
        put(1'b1, $urandom_range(H, 2 * C));
      end
      frame(b, sv, sv ? $urandom_range(H + 1, C + 4) : C, pf);
      if (!sv) put(1'b0, $urandom_range(0, 30));
      put(1'b1, $urandom_range(sv ? 0 : 1, 25));
    end
    frame(8'h81, 1'b1, C, 1'b0);
    put(1'b1, C);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_phase();

`ifdef UART_RX_PARITY_EN
    chk("model_first_valid", 32'(m_first_valid), 32'd180);
`else
    chk("model_first_valid", 32'(m_first_valid), 32'd164);
`endif
    chk("dut_first_valid_t", 32'(dv_t.size() > 0 ? dv_t[0] : -1),
        32'(m_first_valid));
    chk("byte0", 32'(dv_d.size() > 0 ? dv_d[0] : 8'hxx), 32'h A5);
    chk("byte1", 32'(dv_d.size() > 1 ? dv_d[1] : 8'hxx), 32'h00);
    chk("byte2", 32'(dv_d.size() > 2 ? dv_d[2] : 8'hxx), 32'hFF);
    chk("ferr_data_kept", 32'(df_d.size() > 0 ? df_d[0] : 8'hxx), 32'hFF);
`ifdef UART_RX_PARITY_EN
    chk("par_bad_data", 32'(dv_d.size() > 3 ? dv_d[3] : 8'hxx), 32'h07);
    chk("par_bad_flag", 32'(dv_p.size() > 3 ? dv_p[3] : 1'b0), 32'd1);
    chk("par_ok_flag", 32'(dv_p.size() > 4 ? dv_p[4] : 1'b1), 32'd0);
    chk("short_stop", 32'(dv_d.size() > 5 ? dv_d[5] : 8'hxx), 32'hB7);
`else
    chk("short_stop", 32'(dv_d.size() > 3 ? dv_d[3] : 8'hxx), 32'hB7);
`endif
    chk("last_data", 32'(data), 32'h81);

    line.delete();
    put(1'b0, C);
    b = 8'hC3;
    for (int k = 0; k < 4; k++) put(b[k], C);
    put(b[4], 3);
    for (int n = 0; n < line.size(); n++) begin
      rx = line[n];
      @(posedge clk);
      #1;
      chk("abort_valid", 32'(valid), 32'd0);
      chk("abort_ferr", 32'(frame_err), 32'd0);
    end
    chk("abort_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_busy", 32'(busy), 32'd0);
    chk("rst_hold_data", 32'(data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    dv_d.delete();
    line.delete();
    put(1'b1, 6);
    frame(8'h5A, 1'b1, C, 1'b0);
    put(1'b1, 30);
    run_phase();
    chk("post_rst_count", 32'(dv_d.size()), 32'd1);
    chk("post_rst_byte", 32'(dv_d.size() > 0 ? dv_d[0] : 8'hxx), 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
